// File: rtl/reg_fetch.sv
// rtl/reg_fetch.sv - operand-fetch stage sequencing register stack get/set/reset controls.
// Optional macro REG_FETCH_FORWARD_EN: accept writebacks in OUT and forward them into held operands.
module reg_fetch #(
  parameter int NIB_SIZE       = 4,
  parameter int WORD_SIZE      = 16,
  parameter int REG_STACK_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 wb_valid,
  input  logic [NIB_SIZE-1:0]  wb_num,
  input  logic [WORD_SIZE-1:0] wb_val,
  output logic                 wb_ready,
  input  logic                 clear,
  output logic [NIB_SIZE-1:0]  rs_num1,
  output logic [NIB_SIZE-1:0]  rs_num2,
  output logic [NIB_SIZE-1:0]  rs_setnum,
  output logic [WORD_SIZE-1:0] rs_setval,
  output logic                 rs_get_enable,
  output logic                 rs_set_enable,
  output logic                 rs_reset_enable,
  input  logic [WORD_SIZE-1:0] rs_out1,
  input  logic [WORD_SIZE-1:0] rs_out2,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [NIB_SIZE-1:0]  op_code,
  output logic [NIB_SIZE-1:0]  op_dst,
  output logic [WORD_SIZE-1:0] op_a,
  output logic [WORD_SIZE-1:0] op_b
);

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, CAPTURE, OUT} state_t;

  state_t              state, state_next;
  logic [NIB_SIZE-1:0] src1, src2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_code <= '0;
      op_dst  <= '0;
      src1    <= '0;
      src2    <= '0;
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      if (instr_ready) begin
        op_code <= instr[4*NIB_SIZE-1:3*NIB_SIZE];
        op_dst  <= instr[3*NIB_SIZE-1:2*NIB_SIZE];
        src1    <= instr[2*NIB_SIZE-1:NIB_SIZE];
        src2    <= instr[NIB_SIZE-1:0];
      end
      if (state == CAPTURE) begin
        op_a <= rs_out1;
        op_b <= rs_out2;
      end
`ifdef REG_FETCH_FORWARD_EN
      // A write landing while operands are held must also refresh them.
      if (state == OUT && wb_ready) begin
        if (wb_num == src1) op_a <= wb_val;
        if (wb_num == src2) op_b <= wb_val;
      end
`endif
    end
  end

  always_comb begin
    state_next      = state;
    instr_ready     = 1'b0;
    wb_ready        = 1'b0;
    rs_get_enable   = 1'b0;
    rs_set_enable   = 1'b0;
    rs_reset_enable = 1'b0;
    rs_num1         = '0;
    rs_num2         = '0;
    rs_setnum       = '0;
    rs_setval       = '0;
    op_valid        = 1'b0;
    case (state)
      INIT: begin
        rs_reset_enable = 1'b1;
        state_next      = IDLE;
      end
      IDLE: begin
        if (clear) begin
          state_next = INIT;
        end else if (wb_valid) begin
          wb_ready = 1'b1;
        end else if (instr_valid) begin
          instr_ready = 1'b1;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        rs_get_enable = 1'b1;
        rs_num1       = src1;
        rs_num2       = src2;
        state_next    = CAPTURE;
      end
      CAPTURE: state_next = OUT;
      OUT: begin
        op_valid = 1'b1;
`ifdef REG_FETCH_FORWARD_EN
        wb_ready = wb_valid;
`endif
        if (op_ready) state_next = IDLE;
      end
      default: state_next = INIT;
    endcase
    // Writes only ever happen in cycles with no get/reset, so the stack sees one control at a time.
    if (wb_ready) begin
      rs_set_enable = 1'b1;
      rs_setnum     = wb_num;
      rs_setval     = wb_val;
    end
  end

  a_controls_exclusive: assert property (@(posedge clk)
    $countones({rs_get_enable, rs_set_enable, rs_reset_enable}) <= 1);

  a_wb_num_in_range: assert property (@(posedge clk) disable iff (!reset_n)
    int'(wb_num) < REG_STACK_SIZE);

endmodule

// File: tb/tb_reg_fetch.sv
// tb/tb_reg_fetch.sv - randomized self-checking bench for reg_fetch with a behavioural register file.
module tb_reg_fetch;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0, instr_ready;
  logic        wb_valid = 1'b0, wb_ready;
  logic [3:0]  wb_num = '0;
  logic [15:0] wb_val = '0;
  logic        clear = 1'b0;
  logic [3:0]  rs_num1, rs_num2, rs_setnum;
  logic [15:0] rs_setval;
  logic        rs_get_enable, rs_set_enable, rs_reset_enable;
  logic [15:0] rs_out1, rs_out2;
  logic        op_valid, op_ready = 1'b0;
  logic [3:0]  op_code, op_dst;
  logic [15:0] op_a, op_b;

  int checks = 0;
  int fails  = 0;
  logic [15:0] stack    [16];
  logic [15:0] exp_regs [16];

  always #5 clk = ~clk;

  reg_fetch dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .wb_valid(wb_valid), .wb_num(wb_num), .wb_val(wb_val), .wb_ready(wb_ready), .clear(clear),
    .rs_num1(rs_num1), .rs_num2(rs_num2), .rs_setnum(rs_setnum), .rs_setval(rs_setval),
    .rs_get_enable(rs_get_enable), .rs_set_enable(rs_set_enable), .rs_reset_enable(rs_reset_enable),
    .rs_out1(rs_out1), .rs_out2(rs_out2), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_dst(op_dst), .op_a(op_a), .op_b(op_b)
  );

  // Register stack environment: registered reads, clear has priority.
  always @(posedge clk) begin
    if (rs_reset_enable) begin
      for (int i = 0; i < 16; i++) stack[i] <= '0;
    end else if (rs_set_enable) begin
      stack[rs_setnum] <= rs_setval;
    end
    if (rs_get_enable) begin
      rs_out1 <= stack[rs_num1];
      rs_out2 <= stack[rs_num2];
    end
  end

  always @(negedge clk) begin
    checks++;
    if ($countones({rs_get_enable, rs_set_enable, rs_reset_enable}) > 1) begin
      fails++;
      $display("FAIL controls_exclusive: get=%b set=%b reset=%b, at most one required",
               rs_get_enable, rs_set_enable, rs_reset_enable);
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
  endtask

  task automatic wb_write(input logic [3:0] n, input logic [15:0] v);
    @(negedge clk); wb_valid = 1'b1; wb_num = n; wb_val = v;
    @(negedge clk); wb_valid = 1'b0; wb_num = '0; wb_val = '0;
    exp_regs[n] = v;
  endtask

  // Returns at the first negedge with op_valid=1; edges counts clock edges after acceptance.
  task automatic start_op(input logic [15:0] ins, output int edges);
    @(negedge clk); instr = ins; instr_valid = 1'b1;
    edges = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); instr_valid = 1'b0;
      if (op_valid) begin edges = i; break; end
    end
  endtask

  task automatic finish_op();
    op_ready = 1'b1;
    @(negedge clk); op_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (rs_reset_enable !== 1'b1) begin fails++; $display("FAIL reset_rs_reset: got %b want 1", rs_reset_enable); end
    checks++; if (op_valid !== 1'b0) begin fails++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
    checks++; if ({op_a, op_b, op_code, op_dst} !== 40'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", {op_a, op_b, op_code, op_dst}); end
    reset_n = 1'b1; #1;
    checks++; if (rs_reset_enable !== 1'b1) begin fails++; $display("FAIL init_rs_reset: got %b want 1", rs_reset_enable); end
    instr = 16'h1035; instr_valid = 1'b1;
    @(negedge clk); #1;
    checks++; if (rs_reset_enable !== 1'b0) begin fails++; $display("FAIL init_one_cycle: got %b want 0", rs_reset_enable); end
    checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL idle_instr_ready: got %b want 1", instr_ready); end
    instr_valid = 1'b0;
    clear_model();
  endtask

  task automatic test_raw();
    int e;
    wb_write(4'd3, 16'h1234);
    start_op(16'h1035, e);
    checks++; if (e !== 2) begin fails++; $display("FAIL raw_latency: got %0d edges want 2", e); end
    checks++; if (op_a !== 16'h1234) begin fails++; $display("FAIL raw_op_a: got %h want 1234", op_a); end
    checks++; if (op_b !== 16'h0000) begin fails++; $display("FAIL raw_op_b: got %h want 0000", op_b); end
    checks++; if ({op_code, op_dst} !== 8'h10) begin fails++; $display("FAIL raw_code_dst: got %h want 10", {op_code, op_dst}); end
    checks++; if ({rs_num1, rs_num2} !== 8'h00) begin fails++; $display("FAIL raw_nums_idle: got %h want 00", {rs_num1, rs_num2}); end
    finish_op();
    checks++; if (op_valid !== 1'b0) begin fails++; $display("FAIL raw_valid_drop: got %b want 0", op_valid); end
  endtask

  task automatic test_wb_and_instr();
    logic [3:0]  n, s2;
    logic [15:0] v;
    n = 4'($urandom_range(15, 0)); s2 = 4'($urandom_range(15, 0)); v = 16'($urandom);
    @(negedge clk);
    wb_valid = 1'b1; wb_num = n; wb_val = v;
    instr_valid = 1'b1; instr = {4'h9, 4'h2, n, s2}; #1;
    checks++; if ({wb_ready, instr_ready} !== 2'b10) begin fails++; $display("FAIL both_first: got wb_ready/instr_ready %b want 10", {wb_ready, instr_ready}); end
    checks++; if (rs_setval !== v) begin fails++; $display("FAIL both_setval: got %h want %h", rs_setval, v); end
    @(negedge clk); wb_valid = 1'b0; exp_regs[n] = v; #1;
    checks++; if ({instr_ready, rs_set_enable} !== 2'b10) begin fails++; $display("FAIL both_second: got instr_ready/set %b want 10", {instr_ready, rs_set_enable}); end
    @(negedge clk); instr_valid = 1'b0; #1;
    checks++; if ({rs_get_enable, rs_num1, rs_num2} !== {1'b1, n, s2}) begin fails++; $display("FAIL both_issue: got %h want %h", {rs_get_enable, rs_num1, rs_num2}, {1'b1, n, s2}); end
    @(negedge clk); @(negedge clk);
    checks++; if ({op_valid, op_a, op_b} !== {1'b1, v, exp_regs[s2]}) begin fails++; $display("FAIL both_ops: got %h want %h", {op_valid, op_a, op_b}, {1'b1, v, exp_regs[s2]}); end
    finish_op();
  endtask

  task automatic test_stall();
    int e;
    logic [15:0] ins;
    logic [31:0] held;
    ins = 16'($urandom);
    start_op(ins, e);
    held = {exp_regs[ins[7:4]], exp_regs[ins[3:0]]};
`ifndef REG_FETCH_FORWARD_EN
    wb_valid = 1'b1; wb_num = 4'hA; wb_val = 16'h5A5A;
`endif
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({op_valid, op_a, op_b, op_code, op_dst, instr_ready, wb_ready} !== {1'b1, held, ins[15:8], 2'b00}) begin
        fails++;
        $display("FAIL stall_cycle%0d: got v=%b a=%h b=%h ir=%b wr=%b want v=1 ops=%h ir=0 wr=0",
                 i, op_valid, op_a, op_b, instr_ready, wb_ready, held);
      end
    end
    instr_valid = 1'b0;
    finish_op();
`ifndef REG_FETCH_FORWARD_EN
    #1;
    checks++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL stall_wb_waits: got %b want 1 in IDLE", wb_ready); end
    @(negedge clk); wb_valid = 1'b0; exp_regs[4'hA] = 16'h5A5A;
`endif
  endtask

  task automatic test_forward();
`ifdef REG_FETCH_FORWARD_EN
    int e;
    wb_write(4'd7, 16'h0000);
    start_op(16'h3177, e);
    @(negedge clk); wb_valid = 1'b1; wb_num = 4'd7; wb_val = 16'hBEEF; #1;
    checks++; if ({wb_ready, rs_set_enable} !== 2'b11) begin fails++; $display("FAIL fwd_accept: got %b want 11", {wb_ready, rs_set_enable}); end
    @(negedge clk); wb_valid = 1'b0; exp_regs[7] = 16'hBEEF; #1;
    checks++; if ({op_valid, op_a, op_b} !== {1'b1, 16'hBEEF, 16'hBEEF}) begin fails++; $display("FAIL fwd_ops: got %h want 1beefbeef", {op_valid, op_a, op_b}); end
    finish_op();
    start_op(16'h4070, e);
    checks++; if (op_a !== 16'hBEEF) begin fails++; $display("FAIL fwd_readback: got %h want beef", op_a); end
    finish_op();
`endif
  endtask

  task automatic test_clear();
    int e;
    wb_write(4'd2, 16'h00FF);
    start_op(16'h5020, e);
    checks++; if (op_a !== 16'h00FF) begin fails++; $display("FAIL clear_pre: got %h want 00ff", op_a); end
    finish_op();
    @(negedge clk); clear = 1'b1; wb_valid = 1'b1; wb_num = 4'd2; wb_val = 16'h1111;
    instr_valid = 1'b1; instr = 16'h5020; #1;
    checks++; if ({instr_ready, wb_ready} !== 2'b00) begin fails++; $display("FAIL clear_priority: got %b want 00", {instr_ready, wb_ready}); end
    @(negedge clk); clear = 1'b0; wb_valid = 1'b0; instr_valid = 1'b0; #1;
    checks++; if (rs_reset_enable !== 1'b1) begin fails++; $display("FAIL clear_pulse: got %b want 1", rs_reset_enable); end
    clear_model();
    @(negedge clk); #1;
    checks++; if (rs_reset_enable !== 1'b0) begin fails++; $display("FAIL clear_pulse_len: got %b want 0", rs_reset_enable); end
    start_op(16'h5020, e);
    checks++; if (op_a !== 16'h0000) begin fails++; $display("FAIL clear_read: got %h want 0000", op_a); end
    finish_op();
  endtask

  task automatic test_reset_mid();
    int e;
    wb_write(4'd9, 16'hCAFE);
    @(negedge clk); instr = 16'h6399; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk); reset_n = 1'b0; #1;
    checks++; if ({op_valid, rs_reset_enable, instr_ready} !== 3'b010) begin fails++; $display("FAIL rst_capture: got %b want 010", {op_valid, rs_reset_enable, instr_ready}); end
    @(negedge clk); #1;
    checks++; if ({op_code, op_dst, op_a} !== 24'd0) begin fails++; $display("FAIL rst_discard: got %h want 0", {op_code, op_dst, op_a}); end
    reset_n = 1'b1; clear_model();
    @(negedge clk);
    start_op(16'h6399, e);
    checks++; if (op_a !== 16'h0000) begin fails++; $display("FAIL rst_stack_cleared: got %h want 0000", op_a); end
    #2 reset_n = 1'b0; #1;
    checks++; if (op_valid !== 1'b0) begin fails++; $display("FAIL rst_out_async: got %b want 0", op_valid); end
    @(negedge clk); reset_n = 1'b1; clear_model();
    @(negedge clk);
  endtask

  task automatic test_random();
    int e;
    logic [15:0] ins;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(1, 0) == 1) begin
        wb_write(4'($urandom_range(15, 0)), 16'($urandom));
      end else begin
        ins = 16'($urandom);
        start_op(ins, e);
        repeat ($urandom_range(3, 0)) @(negedge clk);
        checks++;
        if ({e[3:0], op_code, op_dst, op_a, op_b} !== {4'd2, ins[15:8], exp_regs[ins[7:4]], exp_regs[ins[3:0]]}) begin
          fails++;
          $display("FAIL rand_op%0d: instr %h got lat=%0d ops=%h want lat=2 ops=%h", k, ins, e,
                   {op_a, op_b}, {exp_regs[ins[7:4]], exp_regs[ins[3:0]]});
        end
        finish_op();
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_wb_and_instr();
    test_stall();
    test_forward();
    test_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
